hazard_stall_unit: RTL and testbench

- Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
- The forwarding logic resolves hazards by bypassing data. This block handles every hazard that bypassing cannot cover:
  - load-use
  - jr/jalr source register produced by an in-flight load
  - HI/LO access while the multi-cycle mult/div unit is busy
  - taken jump/branch squash
- It drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It also owns the mult/div busy countdown and the stall/flush performance counters.

---
 rtl/hazard_stall_unit_pkg.sv | 20 ++
 rtl/hazard_stall_unit_if.sv | 42 ++++
 rtl/hazard_stall_unit_md_busy_tracker.sv | 56 +++++
 rtl/hazard_stall_unit.sv | 87 ++++++++
 tb/tb_hazard_stall_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants and types for the hazard/stall controller and the mult/div unit.
// Keeping latencies here lets the mult/div datapath and the busy tracker agree on timing.
package hazard_stall_unit_pkg;

    localparam logic [5:0] OP_RTYPE     = 6'd0;
    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         MULT_LAT_DEF = 4;
    localparam int         DIV_LAT_DEF  = 32;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    typedef struct packed {
        logic lu;
        logic jrx;
        logic jrm;
        logic md;
    } hazard_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline (master) and the hazard/stall controller (slave).
// All signals are level-qualified per cycle; there is no valid/ready handshake on this bus.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs_id;
    logic [4:0]       Rt_id;
    logic [5:0]       op_id;
    logic             UsesRt_id;
    logic             Jump_id;
    logic             Taken_id;
    logic             MdUse_id;
    logic [4:0]       Rd_ex;
    logic             MemRead_ex;
    logic             MdStart_ex;
    logic             MdIsDiv_ex;
    logic [4:0]       Rd_mem;
    logic             MemRead_mem;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             Bubble_o;
    logic             IFIDFlush_o;
    logic             MdBusy_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;
    logic [0:0]       md_state_dbg;

    modport master (
        output Rs_id, Rt_id, op_id, UsesRt_id, Jump_id, Taken_id, MdUse_id,
        output Rd_ex, MemRead_ex, MdStart_ex, MdIsDiv_ex, Rd_mem, MemRead_mem,
        input  PCWrite_o, IFIDWrite_o, Bubble_o, IFIDFlush_o, MdBusy_o,
        input  StallCnt_o, FlushCnt_o, md_state_dbg
    );

    modport slave (
        input  Rs_id, Rt_id, op_id, UsesRt_id, Jump_id, Taken_id, MdUse_id,
        input  Rd_ex, MemRead_ex, MdStart_ex, MdIsDiv_ex, Rd_mem, MemRead_mem,
        output PCWrite_o, IFIDWrite_o, Bubble_o, IFIDFlush_o, MdBusy_o,
        output StallCnt_o, FlushCnt_o, md_state_dbg
    );

endinterface

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// IDLE/BUSY tracker for HI/LO occupancy by the multi-cycle mult/div unit.
// A start always (re)loads the countdown, even when already busy.
module md_busy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       md_start_i,
    input  logic       md_is_div_i,
    output logic       md_busy_o,
    output logic [0:0] state_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (md_start_i) begin
            state_d = MD_BUSY;
            cnt_d   = md_is_div_i ? DIV_CNT : MULT_CNT;
        end else if (state_q == MD_BUSY) begin
            if (cnt_q == CNT_ONE) begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy_o = (state_q == MD_BUSY);
    assign state_o   = state_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: covers the hazards forwarding cannot,
// and keeps stall/flush performance counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hazard_t          haz;
    logic             is_jr;
    logic             stall;
    logic             flush;
    logic             md_busy;
    logic [0:0]       md_state;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk         (clk),
        .rst         (rst),
        .md_start_i  (hz.MdStart_ex),
        .md_is_div_i (hz.MdIsDiv_ex),
        .md_busy_o   (md_busy),
        .state_o     (md_state)
    );

    // jr/jalr reads rs in ID, so a load in EX or MEM cannot be bypassed in time.
    always_comb begin
        is_jr   = hz.Jump_id && (hz.op_id == OP_RTYPE);
        haz.lu  = hz.MemRead_ex && (hz.Rd_ex != REG_ZERO) &&
                  ((hz.Rd_ex == hz.Rs_id) || (hz.UsesRt_id && (hz.Rd_ex == hz.Rt_id)));
        haz.jrx = is_jr && hz.MemRead_ex && (hz.Rd_ex != REG_ZERO) && (hz.Rd_ex == hz.Rs_id);
        haz.jrm = is_jr && hz.MemRead_mem && (hz.Rd_mem != REG_ZERO) && (hz.Rd_mem == hz.Rs_id);
        haz.md  = hz.MdUse_id && md_busy;
        stall   = |haz;
        flush   = hz.Taken_id && !stall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset holds the front end frozen with a bubble regardless of the inputs.
    always_comb begin
        if (rst) begin
            hz.PCWrite_o   = 1'b0;
            hz.IFIDWrite_o = 1'b0;
            hz.Bubble_o    = 1'b1;
            hz.IFIDFlush_o = 1'b0;
        end else begin
            hz.PCWrite_o   = !stall;
            hz.IFIDWrite_o = !stall;
            hz.Bubble_o    = stall;
            hz.IFIDFlush_o = flush;
        end
    end

    assign hz.MdBusy_o     = md_busy;
    assign hz.StallCnt_o   = stall_cnt_q;
    assign hz.FlushCnt_o   = flush_cnt_q;
    assign hz.md_state_dbg = md_state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: each step drives one pipeline cycle, queues the
// expected control/counter values and checks them mid-cycle.
module tb_hazard_stall_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   mdl_stall;
  int   mdl_flush;

  logic [4:0]  exp_q[$];
  logic [31:0] exp_sc_q[$];
  logic [31:0] exp_fc_q[$];

  hazard_stall_unit_if #(.CNT_W(32)) hz ();

  hazard_stall_unit #(
    .MULT_LAT (4),
    .DIV_LAT  (32),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.Rs_id       = 5'd0;
    hz.Rt_id       = 5'd0;
    hz.op_id       = 6'd0;
    hz.UsesRt_id   = 1'b0;
    hz.Jump_id     = 1'b0;
    hz.Taken_id    = 1'b0;
    hz.MdUse_id    = 1'b0;
    hz.Rd_ex       = 5'd0;
    hz.MemRead_ex  = 1'b0;
    hz.MdStart_ex  = 1'b0;
    hz.MdIsDiv_ex  = 1'b0;
    hz.Rd_mem      = 5'd0;
    hz.MemRead_mem = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic cyc(input logic e_stall, input logic e_flush, input logic e_busy, input string tag);
    logic [4:0]  e_ctl;
    logic [31:0] e_sc;
    logic [31:0] e_fc;
    exp_q.push_back({!e_stall, !e_stall, e_stall, e_flush, e_busy});
    exp_sc_q.push_back(32'(mdl_stall));
    exp_fc_q.push_back(32'(mdl_flush));
    if (e_stall) mdl_stall++;
    if (e_flush) mdl_flush++;
    #2;
    e_ctl = exp_q.pop_front();
    e_sc  = exp_sc_q.pop_front();
    e_fc  = exp_fc_q.pop_front();
    chk({tag, "_ctl"}, {27'd0, hz.PCWrite_o, hz.IFIDWrite_o, hz.Bubble_o, hz.IFIDFlush_o, hz.MdBusy_o},
        {27'd0, e_ctl});
    chk({tag, "_stallcnt"}, hz.StallCnt_o, e_sc);
    chk({tag, "_flushcnt"}, hz.FlushCnt_o, e_fc);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    mdl_stall = 0;
    mdl_flush = 0;
    rst       = 1'b1;
    clear_inputs();
    // Reset with a load-use and a taken branch on the inputs: outputs still forced.
    hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd8; hz.Rs_id = 5'd8; hz.Taken_id = 1'b1;
    #3;
    chk("rst_ctl", {27'd0, hz.PCWrite_o, hz.IFIDWrite_o, hz.Bubble_o, hz.IFIDFlush_o, hz.MdBusy_o},
        {27'd0, 5'b00100});
    chk("rst_stallcnt", hz.StallCnt_o, 32'd0);
    chk("rst_flushcnt", hz.FlushCnt_o, 32'd0);
    chk("rst_mdstate", {31'd0, hz.md_state_dbg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    cyc(0, 0, 0, "idle");

    // Load-use on rs: lw $8 in EX, add $9,$8,$1 in ID.
    hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd8; hz.Rs_id = 5'd8; hz.Rt_id = 5'd1; hz.UsesRt_id = 1'b1;
    cyc(1, 0, 0, "lu_rs");
    hz.MemRead_ex = 1'b0; hz.Rd_ex = 5'd9; hz.MemRead_mem = 1'b1; hz.Rd_mem = 5'd8;
    cyc(0, 0, 0, "lu_release");
    // Load-use on rt, then the same match with rt not read.
    clear_inputs();
    hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd12; hz.Rs_id = 5'd3; hz.Rt_id = 5'd12; hz.UsesRt_id = 1'b1;
    cyc(1, 0, 0, "lu_rt");
    hz.UsesRt_id = 1'b0;
    cyc(0, 0, 0, "lu_rt_unused");

    // jr $31 behind lw $31: two stall cycles, then the flush.
    clear_inputs();
    hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd31; hz.Jump_id = 1'b1; hz.Rs_id = 5'd31; hz.Taken_id = 1'b1;
    cyc(1, 0, 0, "jr_ex");
    hz.MemRead_ex = 1'b0; hz.Rd_ex = 5'd0; hz.MemRead_mem = 1'b1; hz.Rd_mem = 5'd31;
    cyc(1, 0, 0, "jr_mem");
    hz.MemRead_mem = 1'b0; hz.Rd_mem = 5'd0;
    cyc(0, 1, 0, "jr_flush");
    clear_inputs();
    cyc(0, 0, 0, "jr_after");

    // No false stalls: $0 destination, ALU producer for jr, and j (non R-type) with a MEM load.
    hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd0; hz.Rs_id = 5'd0; hz.Rt_id = 5'd0; hz.UsesRt_id = 1'b1;
    cyc(0, 0, 0, "zero_reg");
    clear_inputs();
    hz.Rd_ex = 5'd31; hz.Jump_id = 1'b1; hz.Rs_id = 5'd31; hz.Taken_id = 1'b1;
    cyc(0, 1, 0, "jr_alu");
    clear_inputs();
    hz.op_id = 6'd2; hz.Jump_id = 1'b1; hz.Rs_id = 5'd7; hz.MemRead_mem = 1'b1; hz.Rd_mem = 5'd7;
    hz.Taken_id = 1'b1;
    cyc(0, 1, 0, "j_not_jr");

    // Taken beq held by a load-use: flush only once the stall clears.
    clear_inputs();
    hz.op_id = 6'd4; hz.MemRead_ex = 1'b1; hz.Rd_ex = 5'd5; hz.Rs_id = 5'd5; hz.Rt_id = 5'd6;
    hz.UsesRt_id = 1'b1; hz.Taken_id = 1'b1;
    cyc(1, 0, 0, "br_stall");
    hz.MemRead_ex = 1'b0; hz.MemRead_mem = 1'b1; hz.Rd_mem = 5'd5;
    cyc(0, 1, 0, "br_flush");

    // Multiply: mult in EX with mflo in ID (not stalled), then mflo held 4 cycles.
    clear_inputs();
    hz.MdStart_ex = 1'b1; hz.MdIsDiv_ex = 1'b0; hz.MdUse_id = 1'b1;
    cyc(0, 0, 0, "mul_issue");
    hz.MdStart_ex = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, "mul_busy");
    cyc(0, 0, 0, "mul_release");

    // Divide: mflo held 32 cycles.
    clear_inputs();
    hz.MdStart_ex = 1'b1; hz.MdIsDiv_ex = 1'b1;
    cyc(0, 0, 0, "div_issue");
    hz.MdStart_ex = 1'b0; hz.MdIsDiv_ex = 1'b0; hz.MdUse_id = 1'b1;
    for (int i = 0; i < 32; i++) cyc(1, 0, 1, "div_busy");
    cyc(0, 0, 0, "div_release");

    // Start while busy reloads the countdown.
    clear_inputs();
    hz.MdStart_ex = 1'b1;
    cyc(0, 0, 0, "reload_mul");
    hz.MdStart_ex = 1'b0;
    cyc(0, 0, 1, "reload_wait");
    hz.MdStart_ex = 1'b1; hz.MdIsDiv_ex = 1'b1;
    cyc(0, 0, 1, "reload_div");
    clear_inputs();
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, "reload_busy");
    cyc(0, 0, 0, "reload_done");

    // Reset mid-divide with the countdown at 10.
    hz.MdStart_ex = 1'b1; hz.MdIsDiv_ex = 1'b1;
    cyc(0, 0, 0, "div2_issue");
    hz.MdStart_ex = 1'b0; hz.MdIsDiv_ex = 1'b0; hz.MdUse_id = 1'b1;
    for (int i = 0; i < 22; i++) cyc(1, 0, 1, "div2_busy");
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {27'd0, hz.PCWrite_o, hz.IFIDWrite_o, hz.Bubble_o, hz.IFIDFlush_o, hz.MdBusy_o},
        {27'd0, 5'b00100});
    chk("midrst_stallcnt", hz.StallCnt_o, 32'd0);
    chk("midrst_flushcnt", hz.FlushCnt_o, 32'd0);
    mdl_stall = 0;
    mdl_flush = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, "post_rst_mflo");
    cyc(0, 0, 0, "post_rst_idle");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
